// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks.
//   S_IDLE / S_RUN / S_FIN : FSM state encodings
//   SER_WIDTH_DEF          : default operand width
package serial_arith_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int unsigned SER_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// START/DONE handshake and operand/result bus for serial_subtractor.
//   master : drives START, A, B; observes DIFF, BORROW, BUSY, DONE
//   slave  : the subtractor side
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEF
);

    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] DIFF;
    logic             BORROW;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, A, B,
        input  DIFF, BORROW, BUSY, DONE
    );

    modport slave (
        input  START, A, B,
        output DIFF, BORROW, BUSY, DONE
    );

endinterface

// File: rtl/full_subtractor.sv
// Full subtractor: D = A - B - BIN, built from two half subtractors.
//   A, B : operand bits
//   BIN  : borrow in
//   D    : difference bit
//   BOUT : borrow out
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic D,
    output logic BOUT
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_subtractor u_hs_ab (
        .A    (A),
        .B    (B),
        .D    (w_d1),
        .BOUT (w_b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference;
    // its borrow equals ~(A^B) & BIN, so the two borrows never both fire.
    half_subtractor u_hs_bin (
        .A    (w_d1),
        .B    (BIN),
        .D    (D),
        .BOUT (w_b2)
    );

    assign BOUT = w_b1 | w_b2;

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor: D = A - B for single bits.
//   A, B : operand bits
//   D    : difference bit
//   BOUT : borrow out (A=0, B=1)
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic BOUT
);

    assign D    = A ^ B;
    assign BOUT = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, DIFF = A - B, LSB first, one bit per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_subtractor_if
//          START/A/B in; DIFF/BORROW (registered), BUSY, DONE out
// A START seen in IDLE or FIN loads the operands; WIDTH RUN cycles follow,
// then one FIN cycle with DONE=1. DIFF/BORROW hold until the next completion.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_d;
    logic             w_bo;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor u_fs (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .BIN  (r_borrow),
        .D    (w_d),
        .BOUT (w_bo)
    );

    assign w_accept   = bus.START && ((r_state == S_IDLE) || (r_state == S_FIN));
    // New difference bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
    assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_accept) begin
                        r_a_sr   <= bus.A;
                        r_b_sr   <= bus.B;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_res_sr <= w_res_next;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_bo;
                    if (r_cnt == LAST_BIT) begin
                        r_diff       <= w_res_next;
                        r_borrow_out <= w_bo;
                        r_cnt        <= '0;
                        r_state      <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY   = (r_state == S_RUN);
    assign bus.DONE   = (r_state == S_FIN);
    assign bus.DIFF   = r_diff;
    assign bus.BORROW = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [8:0] exp8[$];
    logic [4:0] exp4[$];
    logic [8:0] e8;
    logic [4:0] e4;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitors: pop one expectation per DONE pulse.
    always @(negedge clk) begin
        if (!rst && bus8.DONE) begin
            checks++;
            if (exp8.size() == 0) begin
                errors++;
                $display("FAIL dut8_unexpected_done actual=%h/%b required=none",
                         bus8.DIFF, bus8.BORROW);
            end else begin
                e8 = exp8.pop_front();
                if ({bus8.BORROW, bus8.DIFF} !== e8) begin
                    errors++;
                    $display("FAIL dut8_result actual=%h/%b required=%h/%b",
                             bus8.DIFF, bus8.BORROW, e8[7:0], e8[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus4.DONE) begin
            checks++;
            if (exp4.size() == 0) begin
                errors++;
                $display("FAIL dut4_unexpected_done actual=%h/%b required=none",
                         bus4.DIFF, bus4.BORROW);
            end else begin
                e4 = exp4.pop_front();
                if ({bus4.BORROW, bus4.DIFF} !== e4) begin
                    errors++;
                    $display("FAIL dut4_result actual=%h/%b required=%h/%b",
                             bus4.DIFF, bus4.BORROW, e4[3:0], e4[4]);
                end
            end
        end
    end

    // One 8-bit operation with latency, BUSY length and DONE width checks.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb);
        int busy_n;
        int done_k;
        exp8.push_back({eb, ed});
        @(posedge clk); #1;
        bus8.START = 1'b1; bus8.A = a; bus8.B = b;
        @(posedge clk); #1;
        bus8.START = 1'b0;
        busy_n = 0;
        done_k = 0;
        for (int k = 1; k <= 20 && done_k == 0; k++) begin
            @(negedge clk);
            if (bus8.BUSY) busy_n++;
            if (bus8.DONE) done_k = k;
        end
        check_int("done_latency", done_k, 9);
        check_int("busy_cycles", busy_n, 8);
        @(negedge clk);
        check_int("done_one_cycle", int'(bus8.DONE), 0);
        check_int("idle_after_fin", int'(bus8.BUSY), 0);
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b);
        int done_k;
        int d;
        d = (int'(a) - int'(b)) & 15;
        exp4.push_back({(a < b), 4'(d)});
        @(posedge clk); #1;
        bus4.START = 1'b1; bus4.A = a; bus4.B = b;
        @(posedge clk); #1;
        bus4.START = 1'b0;
        done_k = 0;
        for (int k = 1; k <= 12 && done_k == 0; k++) begin
            @(negedge clk);
            if (bus4.DONE) done_k = k;
        end
        if (done_k != 5) check_int("dut4_done_latency", done_k, 5);
    endtask

    initial begin
        int done_n;
        int d1;
        int d2;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus8.START = 1'b0; bus8.A = '0; bus8.B = '0;
        bus4.START = 1'b0; bus4.A = '0; bus4.B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_int("reset_diff", int'(bus8.DIFF), 0);
        check_int("reset_borrow", int'(bus8.BORROW), 0);
        check_int("reset_busy", int'(bus8.BUSY), 0);
        check_int("reset_done", int'(bus8.DONE), 0);

        // Basic, wrap-around and boundary vectors.
        do_op8(8'h5A, 8'h23, 8'h37, 1'b0);
        do_op8(8'h10, 8'h20, 8'hF0, 1'b1);
        do_op8(8'h00, 8'h01, 8'hFF, 1'b1);
        do_op8(8'hC3, 8'hC3, 8'h00, 1'b0);
        do_op8(8'hFF, 8'h00, 8'hFF, 1'b0);

        // START while busy is ignored.
        exp8.push_back({1'b0, 8'h3F});
        @(posedge clk); #1;
        bus8.START = 1'b1; bus8.A = 8'h40; bus8.B = 8'h01;
        @(posedge clk); #1;
        bus8.START = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus8.START = 1'b1; bus8.A = 8'h00; bus8.B = 8'h55;
        @(posedge clk); #1;
        bus8.START = 1'b0;
        done_n = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus8.DONE) done_n++;
        end
        check_int("ignored_start_done_count", done_n, 1);
        check_int("ignored_start_diff", int'(bus8.DIFF), 'h3F);

        // Reset mid-RUN aborts with no DONE.
        @(posedge clk); #1;
        bus8.START = 1'b1; bus8.A = 8'h77; bus8.B = 8'h11;
        @(posedge clk); #1;
        bus8.START = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("abort_busy", int'(bus8.BUSY), 0);
        check_int("abort_done", int'(bus8.DONE), 0);
        check_int("abort_diff", int'(bus8.DIFF), 0);
        check_int("abort_borrow", int'(bus8.BORROW), 0);
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.DONE) done_n++;
        end
        check_int("abort_no_done", done_n, 0);

        // START held high: back-to-back operations with no idle gap.
        exp8.push_back({1'b0, 8'h05});
        @(posedge clk); #1;
        bus8.START = 1'b1; bus8.A = 8'h09; bus8.B = 8'h04;
        @(posedge clk);
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus8.DONE) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (k == 9) begin
                bus8.A = 8'h04; bus8.B = 8'h09;
                exp8.push_back({1'b1, 8'hFB});
            end
            if (k == 10) begin
                check_int("b2b_no_gap_busy", int'(bus8.BUSY), 1);
                bus8.START = 1'b0;
            end
        end
        check_int("b2b_first_done", d1, 9);
        check_int("b2b_second_done", d2, 18);

        // Exhaustive 4-bit sweep against the modular reference.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op4(4'(a), 4'(b));
            end
        end
        repeat (3) @(negedge clk);

        check_int("exp8_drained", exp8.size(), 0);
        check_int("exp4_drained", exp4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
